// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline registers of the five-stage MIPS core.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam int          TNEW_W    = 2;

  localparam logic [TNEW_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/pipe_field.sv
// One pipeline-register field: a W-bit flop with reset value, hold,
// bubble (clear) value and normal load.
module pipe_field #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Field register: reset beats hold, hold beats bubble, bubble beats load
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RST_VAL;
    end else if (hold) begin
      q_r <= q_r;
    end else if (clr) begin
      q_r <= clr_val;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/de_pipe_reg.sv
// D/E pipeline register: captures decode results for the E stage, with
// bubble insertion on stall, hold while E is busy, and a registered PC+8.
module de_pipe_reg #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter int          TNEW_W   = pipe_pkg::TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              clr,
  input  logic [31:0]       instr_D,
  input  logic [31:0]       pc_D,
  input  logic [31:0]       rs_D,
  input  logic [31:0]       rt_D,
  input  logic [31:0]       ext_D,
  input  logic [4:0]        a3_D,
  input  logic [TNEW_W-1:0] tnew_D,
  input  logic              valid_D,
  output logic [31:0]       instr_E,
  output logic [31:0]       pc_E,
  output logic [31:0]       pc8_E,
  output logic [31:0]       rs_E,
  output logic [31:0]       rt_E,
  output logic [31:0]       ext_E,
  output logic [4:0]        a3_E,
  output logic [TNEW_W-1:0] tnew_E,
  output logic              valid_E
);

  localparam logic [31:0] RESET_PC8 = RESET_PC + 32'd8;

  logic [31:0]       pc8_d_s;
  logic [4:0]        a3_ld_s;
  logic [TNEW_W-1:0] tnew_ld_s;

  assign pc8_d_s = pc_D + 32'd8;

  // An invalid slot must never match in the forwarding/hazard compares
  always_comb begin
    a3_ld_s   = 5'd0;
    tnew_ld_s = {TNEW_W{1'b0}};
    if (valid_D) begin
      a3_ld_s   = a3_D;
      tnew_ld_s = tnew_D;
    end else begin
      a3_ld_s   = 5'd0;
      tnew_ld_s = {TNEW_W{1'b0}};
    end
  end

  pipe_field #(.W(32), .RST_VAL(pipe_pkg::NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(pipe_pkg::NOP_INSTR), .d(instr_D), .q(instr_E)
  );

  // The bubble keeps the stalled instruction's PC for exception reporting
  pipe_field #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(pc_D), .d(pc_D), .q(pc_E)
  );

  pipe_field #(.W(32), .RST_VAL(RESET_PC8)) u_pc8 (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(pc8_d_s), .d(pc8_d_s), .q(pc8_E)
  );

  pipe_field #(.W(32), .RST_VAL(32'd0)) u_rs (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(32'd0), .d(rs_D), .q(rs_E)
  );

  pipe_field #(.W(32), .RST_VAL(32'd0)) u_rt (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(32'd0), .d(rt_D), .q(rt_E)
  );

  pipe_field #(.W(32), .RST_VAL(32'd0)) u_ext (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(32'd0), .d(ext_D), .q(ext_E)
  );

  pipe_field #(.W(5), .RST_VAL(5'd0)) u_a3 (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(5'd0), .d(a3_ld_s), .q(a3_E)
  );

  pipe_field #(.W(TNEW_W), .RST_VAL({TNEW_W{1'b0}})) u_tnew (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val({TNEW_W{1'b0}}), .d(tnew_ld_s), .q(tnew_E)
  );

  pipe_field #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .reset(reset), .hold(hold), .clr(clr),
    .clr_val(1'b0), .d(valid_D), .q(valid_E)
  );

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D/E pipeline register of the five-stage MIPS core.
- Captures the decode-stage results (instruction word, PC, forwarded rs/rt operands, the extended immediate from the D-stage extender, destination register, Tnew) and presents them to the E stage.
- Implements bubble insertion on a D-stage stall, holding while the E stage is busy, and a registered PC+8 for link instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TNEW_W, 2, width of the Tnew field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  E stage busy; register keeps its contents.
- clr  in  1  insert bubble (D-stage stall from hazard unit).
- instr_D  in  32  decoded instruction word.
- pc_D  in  32  PC of instr_D.
- rs_D  in  32  forwarded rs operand.
- rt_D  in  32  forwarded rt operand.
- ext_D  in  32  extended immediate from extender.
- a3_D  in  5  destination register address (0 = no write).
- tnew_D  in  TNEW_W  cycles until result is ready, measured at E entry.
- valid_D  in  1  instr_D is a real instruction.
- instr_E, pc_E, rs_E, rt_E, ext_E  out  32 each  registered copies.
- pc8_E  out  32  registered pc_D+8.
- a3_E  out  5  registered destination.
- tnew_E  out  TNEW_W  registered Tnew.
- valid_E  out  1  registered valid.

Behaviour:
- All outputs are registered and change only on the rising clk edge. Latency is 1 cycle from D inputs to E outputs. There is no combinational path from inputs to outputs.
- Priority per edge: reset > hold > clr > load.
- Reset:
  - instr_E=0, rs_E=rt_E=ext_E=0.
  - pc_E=RESET_PC, pc8_E=RESET_PC+8.
  - a3_E=0, tnew_E=0, valid_E=0.
- hold=1: every output keeps its value. hold beats clr because clearing a held stage would destroy the instruction still executing.
- clr=1, hold=0 (bubble):
  - instr_E=0 (sll $0 nop), rs_E=rt_E=ext_E=0.
  - a3_E=0, tnew_E=0, valid_E=0.
  - pc_E=pc_D and pc8_E=pc_D+8, so the bubble carries the stalled instruction's PC for later exception reporting.
- Load (hold=0, clr=0):
  - Every _E output takes its _D counterpart.
  - pc8_E = pc_D + 32'd8, computed modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0004.
- valid_D=0 on load: fields are loaded as presented, but a3_E is forced to 0 and tnew_E to 0. An invalid slot therefore never matches in the forwarding or hazard compare.
- a3_D=0 on load: stored as 0 and treated downstream as no write. No special handling here.
- Consecutive clr cycles produce consecutive bubbles. Deasserting clr loads the current D inputs on the next edge.
- Reset asserted mid-hold or mid-clr: reset wins on that edge. The register holds reset values until the first edge with reset=0.
- Tnew is stored unmodified. Decrementing is the E/M register's job.

Decomposition:
- Shared package (pipe_pkg) holds:
  - NOP_INSTR=32'h0000_0000
  - RESET_PC default
  - TNEW_W
  - TNEW_ALU=1, TNEW_LOAD=2, TNEW_NONE=0
- Natural sub-module: pipe_field. It is a parameterised-width flop with reset value, hold, clr value and load, instantiated once per field. The F/D and E/M registers reuse it.
- pc8 adder stays in the top level.

Test Plan:
- Reset for 2 cycles, then release with all inputs 0 -> pc_E=32'h3000, pc8_E=32'h3008, valid_E=0, a3_E=0, instr_E=0.
- Load instr_D=32'h3402_1234 (ori $2,$0,0x1234), pc_D=32'h3004, ext_D=32'h0000_1234, a3_D=2, tnew_D=1, valid_D=1 -> next edge instr_E=32'h3402_1234, ext_E=32'h1234, pc8_E=32'h300C, a3_E=2, tnew_E=1.
- clr=1 for one edge with the same inputs -> instr_E=0, a3_E=0, tnew_E=0, valid_E=0, pc_E=32'h3004. Next edge with clr=0 loads the ori.
- hold=1 and clr=1 together for 3 edges after the ori is loaded -> all outputs stay equal to the ori values. Releasing both loads the new D inputs.
- valid_D=0 with a3_D=5, tnew_D=2 -> a3_E=0, tnew_E=0, valid_E=0.
- pc_D=32'hFFFF_FFFC load -> pc8_E=32'h0000_0004. Reset asserted during hold=1 -> reset values on that edge.
